// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response signal bundle for the shared-ALU arbiter.
// Latency: none (wiring only).
// Backpressure: carries the per-requester valid/ready and the response valid/ready pairs.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]        Req_Valid;
    logic [NUM_REQ-1:0]        Req_Ready;
    logic [NUM_REQ*DATA_W-1:0] Req_Src1;
    logic [NUM_REQ*DATA_W-1:0] Req_Src2;
    logic [NUM_REQ*3-1:0]      Req_Ctrl;
    logic [DATA_W-1:0]         ALU_Src1;
    logic [DATA_W-1:0]         ALU_Src2;
    logic [2:0]                ALU_Ctrl;
    logic [DATA_W-1:0]         ALU_Result;
    logic                      ALU_Zero;
    logic                      Rsp_Valid;
    logic                      Rsp_Ready;
    logic [ID_W-1:0]           Rsp_Id;
    logic [DATA_W-1:0]         Rsp_Result;
    logic                      Rsp_Zero;
    logic                      Busy;

    // Environment side: requesters, the ALU itself and the response consumer.
    modport master (
        output Req_Valid, Req_Src1, Req_Src2, Req_Ctrl, ALU_Result, ALU_Zero, Rsp_Ready,
        input  Req_Ready, ALU_Src1, ALU_Src2, ALU_Ctrl, Rsp_Valid, Rsp_Id, Rsp_Result,
               Rsp_Zero, Busy
    );

    modport slave (
        input  Req_Valid, Req_Src1, Req_Src2, Req_Ctrl, ALU_Result, ALU_Zero, Rsp_Ready,
        output Req_Ready, ALU_Src1, ALU_Src2, ALU_Ctrl, Rsp_Valid, Rsp_Id, Rsp_Result,
               Rsp_Zero, Busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters, one op in flight.
// Latency: accept edge -> 1 ISSUE cycle -> response valid from the 2nd cycle after accept.
// Backpressure: Req_Ready only in IDLE; response held stable until Rsp_Ready.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Ctrl code with zero operands makes the ALU produce a defined 0 while unused.
    localparam logic [2:0] CTRL_PARK = 3'b111;

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     rr_next;
    logic [DATA_W-1:0]   src1_q;
    logic [DATA_W-1:0]   src2_q;
    logic [2:0]          ctrl_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;

    logic [NUM_REQ-1:0]  hi_mask;
    logic [NUM_REQ-1:0]  hi_req;
    logic [NUM_REQ-1:0]  sel_req;
    logic [ID_W-1:0]     grant_idx;
    logic                req_any;
    logic [NUM_REQ-1:0]  req_ready;
    logic                accept;
    logic [DATA_W-1:0]   sel_src1;
    logic [DATA_W-1:0]   sel_src2;
    logic [2:0]          sel_ctrl;

    assign req_any = |bus.Req_Valid;

    // Requests at or above the pointer win; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (ID_W'(i) >= rr_q);
        end
        hi_req    = bus.Req_Valid & hi_mask;
        sel_req   = (|hi_req) ? hi_req : bus.Req_Valid;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (sel_req[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_src1 = bus.Req_Src1[i*DATA_W +: DATA_W];
                sel_src2 = bus.Req_Src2[i*DATA_W +: DATA_W];
                sel_ctrl = bus.Req_Ctrl[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RST && req_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_idx == ID_W'(i));
                    end
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.Rsp_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers are parked after ISSUE so the ALU inputs are only live for that cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= CTRL_PARK;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                src1_q   <= sel_src1;
                src2_q   <= sel_src2;
                ctrl_q   <= sel_ctrl;
                rsp_id_q <= grant_idx;
                rr_q     <= rr_next;
            end
            if (state_q == ISSUE) begin
                rsp_result_q <= bus.ALU_Result;
                rsp_zero_q   <= bus.ALU_Zero;
                src1_q       <= '0;
                src2_q       <= '0;
                ctrl_q       <= CTRL_PARK;
            end
        end
    end

    assign bus.Req_Ready  = req_ready;
    assign bus.ALU_Src1   = src1_q;
    assign bus.ALU_Src2   = src2_q;
    assign bus.ALU_Ctrl   = ctrl_q;
    assign bus.Rsp_Valid  = (state_q == RESP);
    assign bus.Rsp_Id     = rsp_id_q;
    assign bus.Rsp_Result = rsp_result_q;
    assign bus.Rsp_Zero   = rsp_zero_q;
    assign bus.Busy       = (state_q != IDLE);

endmodule
